// File: rtl/robo_controlador.sv
// Left-hand wall-following robot controller: settle, sample sensors, turn or move.
// Optional STUCK_DETECT_EN: four consecutive right turns without a move end the run in STUCK.
module robo_controlador #(
    parameter logic [15:0] MAX_PASSOS     = 16'd400,
    parameter logic [3:0]  SETTLE_CYC     = 4'd1,
    parameter logic [2:0]  ORIENT_INICIAL = 3'b011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        head,
    input  logic        left,
    output logic [2:0]  acao,
    output logic [2:0]  orientacao,
    output logic [15:0] passos,
    output logic        busy,
    output logic        done,
    output logic        stuck
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_MOVE,
        S_DONE
`ifdef STUCK_DETECT_EN
        , S_STUCK
`endif
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;

    // Heading codes: 001 north, 010 west, 011 east, 100 south.
    function automatic logic [2:0] rot_left(input logic [2:0] o);
        case (o)
            3'b001:  rot_left = 3'b010;
            3'b010:  rot_left = 3'b100;
            3'b100:  rot_left = 3'b011;
            default: rot_left = 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] rot_right(input logic [2:0] o);
        case (o)
            3'b001:  rot_right = 3'b011;
            3'b011:  rot_right = 3'b100;
            3'b100:  rot_right = 3'b010;
            default: rot_right = 3'b001;
        endcase
    endfunction

`ifdef STUCK_DETECT_EN
    logic [2:0] turns;
`else
    assign stuck = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            orientacao <= ORIENT_INICIAL;
            passos     <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= 4'd0;
`ifdef STUCK_DETECT_EN
            turns      <= 3'd0;
            stuck      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        passos     <= 16'd0;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_CYC - 4'd1;
                        state      <= S_SETTLE;
`ifdef STUCK_DETECT_EN
                        turns      <= 3'd0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) state <= S_DECIDE;
                    else                    settle_cnt <= settle_cnt - 4'd1;
                end
                S_DECIDE: begin
                    if (passos == MAX_PASSOS) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (!left) begin
                        orientacao <= rot_left(orientacao);
                        state      <= S_MOVE;
                    end else if (!head) begin
                        state <= S_MOVE;
                    end else begin
`ifdef STUCK_DETECT_EN
                        // The fourth blocked turn ends the run instead of turning again.
                        if (turns == 3'd3) begin
                            turns <= 3'd4;
                            busy  <= 1'b0;
                            stuck <= 1'b1;
                            state <= S_STUCK;
                        end else begin
                            turns      <= turns + 3'd1;
                            orientacao <= rot_right(orientacao);
                            settle_cnt <= SETTLE_CYC - 4'd1;
                            state      <= S_SETTLE;
                        end
`else
                        orientacao <= rot_right(orientacao);
                        settle_cnt <= SETTLE_CYC - 4'd1;
                        state      <= S_SETTLE;
`endif
                    end
                end
                S_MOVE: begin
                    if (passos != 16'hFFFF) passos <= passos + 16'd1;
                    settle_cnt <= SETTLE_CYC - 4'd1;
                    state      <= S_SETTLE;
`ifdef STUCK_DETECT_EN
                    turns      <= 3'd0;
`endif
                end
                default: ;  // terminal states hold until reset
            endcase
        end
    end

    // Move command depends only on registered state and heading.
    always_comb begin
        acao = 3'b000;
        if (state == S_MOVE) begin
            case (orientacao)
                3'b001:  acao = 3'b001;
                3'b010:  acao = 3'b010;
                3'b011:  acao = 3'b100;
                3'b100:  acao = 3'b011;
                default: acao = 3'b000;
            endcase
        end
    end

endmodule
